svm_dot_engine: RTL and testbench
=================================

# svm_dot_engine

Parametrised, pipelined SVM dot-product engine: accumulates a signed fixed-point window of `LANES × BEATS` feature·coefficient products plus a bias, and returns a saturated score per detection window. It sits between the HOG block-feature buffer and the window classifier threshold. It is the streaming successor of the fixed 36-product SVM parallel element, with:
- configurable lane count and beat depth;
- a valid/ready handshake with backpressure;
- full-precision internal accumulation, selectable rounding and saturation reporting.

## Interface
- `FEA_I`, 4, integer bits of features, coefficients, bias and result (sign included)
- `FEA_F`, 28, fractional bits
- `LANES`, 9, products computed per beat
- `BEATS`, 4, beats per window (window = `LANES*BEATS` products)
- `RND_MODE`, 1, 0 = truncate product to `FEA_F` frac bits; 1 = round half up (add 2^(FEA_F-1) before truncation, both signs)

Ports (N = `FEA_I+FEA_F`):
- `clk` in 1, sole clock, rising edge
- `rst` in 1, reset, asynchronous, active-low
- `i_fea` in `LANES*N`, lane k at `[(k+1)*N-1 : k*N]`, two's complement
- `i_coef` in `LANES*N`, same packing
- `i_bias` in N, sampled only on the first beat of a window
- `i_valid` in 1, beat present
- `i_ready` out 1, engine accepts beat (beat accepted when `i_valid && i_ready`)
- `i_clear` in 1, synchronous abort of the current window
- `o_data` out N, saturated window score
- `o_sat` out 1, `o_data` was clipped
- `o_valid` out 1, result present
- `o_ready` in 1, consumer accepts result

## Operation
- Product: full 2N-bit signed product per lane, rounded per `RND_MODE` to `FEA_F` frac bits, keeping `2*FEA_I` integer bits (PW = N+FEA_I); no product truncation at the integer end.
- Lane sum: adder tree of `LANES` products; width PW+clog2(LANES).
- Accumulator: width ACC_W = PW+clog2(LANES*BEATS)+1.
  - Beat 0: acc = sign-extended bias + lane sum.
  - Other beats: acc += lane sum.
- Result: on the last beat, the final acc is clipped to [−2^(N−1), 2^(N−1)−1].
  - `o_sat` = 1 iff clipping occurred.
  - The result is written to `o_data`, `o_valid` is set, and acc is cleared.
- Beat counter: 0..BEATS−1, advances per accepted beat, wraps to 0 after BEATS−1. Each pipeline entry carries `first`/`last` tags derived from the counter.
- Handshake:
  - advance = !o_valid || o_ready; `i_ready` = advance.
  - The whole pipeline stalls when advance = 0. Stage registers and `o_data` hold; no beat is lost or duplicated.
- Result handoff:
  - `o_valid` clears on the edge with `o_ready`, unless a new result is written on the same edge (then it stays 1 with new data).
  - `o_data`/`o_sat` are stable while `o_valid && !o_ready`.
- `i_clear`: on the next edge clears counter, accumulator, stage valids and `o_valid`; dominates a simultaneous accepted beat, which is discarded.
- Reset (any time, incl. mid-window): all registers 0; `o_data`=0, `o_sat`=0, `o_valid`=0; `i_ready`=1 from the first cycle after release.

## Timing
- Stage 1: rounded products registered on the accepting edge T.
- Stage 2: lane sum registered at T+1.
- Stage 3: accumulate; `o_valid` rises at T+2 for the last beat (visible in cycle T+3).
- Latency assumes no stall; each stall cycle adds one.
- Throughput: one beat per cycle; back-to-back windows need no idle cycle, given `o_ready` high.
- A new window's beat 0 may be accepted on the edge right after the previous last beat.

## Structure
- Shared package `svm_pkg`:
  - width functions PW, ACC_W;
  - rounding-mode constants `RND_TRUNC=0`, `RND_HALF_UP=1`;
  - saturation function `sat_to_n`.
- Sub-module `svm_lane_mult`: one signed multiply + rounding/resizing; instantiated `LANES` times.
- Adder tree and accumulator live in the top.

## Test plan
Defaults unless stated; 1.0 = 0x10000000.

1. **Basic window.** Lane 0 fea 1.0, coef 0.25 on all 4 beats; other lanes 0; bias −0.5 (0xF8000000).
   - o_data=0x08000000, o_sat=0.
   - o_valid rises at edge last+2.
2. **Saturation.** All fea 1.0, coef 0.5, bias 0 (sum 18.0).
   - o_data=0x7FFFFFFF, o_sat=1.
   - Negated coef: o_data=0x80000000, o_sat=1.
3. **Rounding.** Single nonzero product: fea 0x00000001 × coef 0x08000000 (0.5 LSB).
   - RND_MODE=1: result 0x00000001; with fea 0xFFFFFFFF: 0x00000000.
   - RND_MODE=0: results 0x00000000 and 0xFFFFFFFF.
4. **Backpressure.** Two back-to-back windows with o_ready low for 5 cycles after the first result.
   - i_ready low while o_valid && !o_ready.
   - First o_data unchanged during the stall; second result correct, with no lost or duplicated beat.
5. **Abort / reset.** i_clear asserted together with beat 2 of a window, then a full clean window.
   - The clean window's result equals its standalone value.
   - Repeat with rst pulsed low mid-window: all outputs 0 immediately; next window correct.
6. **Parametrisation.** LANES=4, BEATS=1; random vectors against a full-precision reference model over 1000 windows.
   - Bit-exact o_data/o_sat.

Source files
------------

// File: rtl/svm_pkg.sv
// Shared widths, rounding-mode constants and the output clipping helper for
// the SVM dot-product engine.
package svm_pkg;

    localparam int RND_TRUNC   = 0;
    localparam int RND_HALF_UP = 1;

    // Wide enough for any accumulator this engine can be configured with.
    localparam int SAT_MAX_W = 128;

    typedef struct packed {
        logic                 sat;
        logic [SAT_MAX_W-1:0] val;
    } sat_res_t;

    // Rounded product width: 2*FEA_I integer bits plus FEA_F fraction bits.
    function automatic int pw(input int fea_i, input int fea_f);
        return 2 * fea_i + fea_f;
    endfunction

    // Accumulator width: product width plus growth for every product in a window and the bias.
    function automatic int acc_w(input int fea_i, input int fea_f, input int lanes, input int beats);
        return pw(fea_i, fea_f) + $clog2(lanes * beats) + 1;
    endfunction

    // Clip a sign-extended value into an n-bit two's complement range.
    function automatic sat_res_t sat_to_n(input logic signed [SAT_MAX_W-1:0] val, input int n);
        logic signed [SAT_MAX_W-1:0] hi_s;
        logic signed [SAT_MAX_W-1:0] lo_s;
        sat_res_t                    res_s;
        hi_s = (128'sd1 <<< (n - 1)) - 128'sd1;
        lo_s = -hi_s - 128'sd1;
        if (val > hi_s) begin
            res_s = '{sat: 1'b1, val: hi_s};
        end else if (val < lo_s) begin
            res_s = '{sat: 1'b1, val: lo_s};
        end else begin
            res_s = '{sat: 1'b0, val: val};
        end
        return res_s;
    endfunction

endpackage

// File: rtl/svm_dot_engine_lane_mult.sv
// One lane of the engine: full-precision signed multiply, optional round half
// up, then drop FEA_F fraction bits while keeping all integer bits.
module svm_lane_mult
    import svm_pkg::*;
#(
    parameter  int FEA_I    = 4,
    parameter  int FEA_F    = 28,
    parameter  int RND_MODE = 1,
    localparam int N        = FEA_I + FEA_F,
    localparam int PW_W     = 2 * FEA_I + FEA_F
) (
    input  logic signed [N-1:0]    fea,
    input  logic signed [N-1:0]    coef,
    output logic signed [PW_W-1:0] prod
);

    // Half of the retained LSB; the largest product magnitude leaves headroom for it.
    localparam logic signed [2*N-1:0] HALF = (2 * N)'(1'b1) <<< (FEA_F - 1);

    logic signed [2*N-1:0] full_s;
    logic signed [2*N-1:0] rnd_s;

    // Multiply, round and rescale to FEA_F fraction bits.
    always_comb begin
        full_s = (2 * N)'(fea) * (2 * N)'(coef);
        if (RND_MODE == RND_HALF_UP) begin
            rnd_s = full_s + HALF;
        end else begin
            rnd_s = full_s;
        end
        prod = PW_W'(rnd_s >>> FEA_F);
    end

endmodule

// File: rtl/svm_dot_engine.sv
// Streaming SVM dot-product engine: LANES products per beat, BEATS beats per
// window, bias added on the first beat, saturated score on the last beat.
// Three pipeline stages that all stall together under output backpressure.
module svm_dot_engine
    import svm_pkg::*;
#(
    parameter  int FEA_I    = 4,
    parameter  int FEA_F    = 28,
    parameter  int LANES    = 9,
    parameter  int BEATS    = 4,
    parameter  int RND_MODE = 1,
    localparam int N        = FEA_I + FEA_F
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LANES*N-1:0] i_fea,
    input  logic [LANES*N-1:0] i_coef,
    input  logic [N-1:0]       i_bias,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic               i_clear,
    output logic [N-1:0]       o_data,
    output logic               o_sat,
    output logic               o_valid,
    input  logic               o_ready
);

    localparam int PW_W  = pw(FEA_I, FEA_F);
    localparam int SUM_W = PW_W + $clog2(LANES);
    localparam int ACC_W = acc_w(FEA_I, FEA_F, LANES, BEATS);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic                    advance_s;
    logic                    accept_s;
    logic [CNT_W-1:0]        cnt_r;
    logic signed [PW_W-1:0]  prod_s    [LANES];
    logic signed [PW_W-1:0]  s1_prod_r [LANES];
    logic                    s1_valid_r;
    logic                    s1_first_r;
    logic                    s1_last_r;
    logic signed [N-1:0]     s1_bias_r;
    logic signed [SUM_W-1:0] lane_sum_s;
    logic signed [SUM_W-1:0] s2_sum_r;
    logic                    s2_valid_r;
    logic                    s2_first_r;
    logic                    s2_last_r;
    logic signed [N-1:0]     s2_bias_r;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] acc_next_s;
    sat_res_t                sat_res_s;
    logic                    unused_sat_hi_s;

    assign advance_s = !o_valid || o_ready;
    assign accept_s  = i_valid && advance_s;
    assign i_ready   = advance_s;

    // The clipped value above bit N-1 only repeats the sign.
    assign unused_sat_hi_s = ^sat_res_s.val[SAT_MAX_W-1:N];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        svm_lane_mult #(
            .FEA_I   (FEA_I),
            .FEA_F   (FEA_F),
            .RND_MODE(RND_MODE)
        ) u_mult (
            .fea (i_fea[k*N +: N]),
            .coef(i_coef[k*N +: N]),
            .prod(prod_s[k])
        );
    end

    // Stage 1: register rounded products, beat tags and the window bias; track beat index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r      <= {CNT_W{1'b0}};
            s1_valid_r <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_bias_r  <= {N{1'b0}};
            for (int k = 0; k < LANES; k++) begin
                s1_prod_r[k] <= {PW_W{1'b0}};
            end
        end else if (i_clear) begin
            cnt_r      <= {CNT_W{1'b0}};
            s1_valid_r <= 1'b0;
        end else if (advance_s) begin
            s1_valid_r <= i_valid;
            s1_first_r <= (cnt_r == {CNT_W{1'b0}});
            s1_last_r  <= (cnt_r == LAST_BEAT);
            for (int k = 0; k < LANES; k++) begin
                s1_prod_r[k] <= prod_s[k];
            end
            if (accept_s && (cnt_r == {CNT_W{1'b0}})) begin
                s1_bias_r <= i_bias;
            end
            if (accept_s) begin
                cnt_r <= (cnt_r == LAST_BEAT) ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1'b1);
            end
        end
    end

    // Sum all lane products of the beat held in stage 1.
    always_comb begin
        lane_sum_s = {SUM_W{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            lane_sum_s = lane_sum_s + SUM_W'(s1_prod_r[k]);
        end
    end

    // Stage 2: register the lane sum with its tags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_r <= 1'b0;
            s2_first_r <= 1'b0;
            s2_last_r  <= 1'b0;
            s2_sum_r   <= {SUM_W{1'b0}};
            s2_bias_r  <= {N{1'b0}};
        end else if (i_clear) begin
            s2_valid_r <= 1'b0;
        end else if (advance_s) begin
            s2_valid_r <= s1_valid_r;
            s2_first_r <= s1_first_r;
            s2_last_r  <= s1_last_r;
            s2_sum_r   <= lane_sum_s;
            s2_bias_r  <= s1_bias_r;
        end
    end

    // Next accumulator value: the first beat restarts from the bias.
    always_comb begin
        if (s2_first_r) begin
            acc_next_s = ACC_W'(s2_bias_r) + ACC_W'(s2_sum_r);
        end else begin
            acc_next_s = acc_r + ACC_W'(s2_sum_r);
        end
        sat_res_s = sat_to_n(SAT_MAX_W'(acc_next_s), N);
    end

    // Stage 3: accumulate, and on the last beat publish the clipped score.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r   <= {ACC_W{1'b0}};
            o_data  <= {N{1'b0}};
            o_sat   <= 1'b0;
            o_valid <= 1'b0;
        end else if (i_clear) begin
            acc_r   <= {ACC_W{1'b0}};
            o_valid <= 1'b0;
        end else if (advance_s) begin
            if (s2_valid_r && s2_last_r) begin
                o_data  <= sat_res_s.val[N-1:0];
                o_sat   <= sat_res_s.sat;
                o_valid <= 1'b1;
                acc_r   <= {ACC_W{1'b0}};
            end else if (s2_valid_r) begin
                acc_r   <= acc_next_s;
                o_valid <= 1'b0;
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_svm_dot_engine.sv
// Scoreboard bench: dut0 uses the default shape (9 lanes, 4 beats, round half
// up); dut1 uses 4 lanes, 1 beat, truncation. Expected scores come from a
// longint reference model or hand-derived constants.
module tb_svm_dot_engine;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [9*N-1:0] fea0 = '0, coef0 = '0;
    logic [N-1:0]   bias0 = '0, o_data0;
    logic           valid0 = 1'b0, clear0 = 1'b0, o_ready0 = 1'b1;
    logic           ready0, o_sat0, o_valid0;

    logic [4*N-1:0] fea1 = '0, coef1 = '0;
    logic [N-1:0]   bias1 = '0, o_data1;
    logic           valid1 = 1'b0, clear1 = 1'b0, o_ready1 = 1'b1;
    logic           ready1, o_sat1, o_valid1;

    svm_dot_engine #(.LANES(9), .BEATS(4), .RND_MODE(1)) dut0 (
        .clk(clk), .rst(rst), .i_fea(fea0), .i_coef(coef0), .i_bias(bias0),
        .i_valid(valid0), .i_ready(ready0), .i_clear(clear0),
        .o_data(o_data0), .o_sat(o_sat0), .o_valid(o_valid0), .o_ready(o_ready0)
    );

    svm_dot_engine #(.LANES(4), .BEATS(1), .RND_MODE(0)) dut1 (
        .clk(clk), .rst(rst), .i_fea(fea1), .i_coef(coef1), .i_bias(bias1),
        .i_valid(valid1), .i_ready(ready1), .i_clear(clear1),
        .o_data(o_data1), .o_sat(o_sat1), .o_valid(o_valid1), .o_ready(o_ready1)
    );

    int total = 0;
    int bad   = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [9*N-1:0] wf [4];
    logic [9*N-1:0] wc [4];
    logic [N-1:0]   wb;
    bit rnd_rdy0 = 1'b0;
    bit rnd_rdy1 = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint rprod(input longint a, input longint b, input bit rnd);
        longint p;
        p = a * b;
        if (rnd) p = p + 64'sd134217728;
        return p >>> 28;
    endfunction

    function automatic logic [32:0] clip(input longint s);
        if (s > 64'sd2147483647) return {1'b1, 32'h7FFFFFFF};
        else if (s < -64'sd2147483648) return {1'b1, 32'h80000000};
        else return {1'b0, s[31:0]};
    endfunction

    function automatic logic [32:0] model0();
        longint s;
        s = longint'($signed(wb));
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 9; k++)
                s += rprod(longint'($signed(wf[b][k*N +: N])), longint'($signed(wc[b][k*N +: N])), 1'b1);
        return clip(s);
    endfunction

    function automatic logic [32:0] model1(input logic [4*N-1:0] f, input logic [4*N-1:0] c, input logic [N-1:0] b);
        longint s;
        s = longint'($signed(b));
        for (int k = 0; k < 4; k++)
            s += rprod(longint'($signed(f[k*N +: N])), longint'($signed(c[k*N +: N])), 1'b0);
        return clip(s);
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] v;
        int sh;
        v  = $urandom;
        sh = $urandom_range(0, 10);
        return 32'($signed(v) >>> sh);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_win();
        for (int b = 0; b < 4; b++) begin
            wf[b] = '0;
            wc[b] = '0;
        end
        wb = '0;
    endtask

    task automatic win_basic();
        clear_win();
        for (int b = 0; b < 4; b++) begin
            wf[b][31:0] = 32'h10000000;
            wc[b][31:0] = 32'h04000000;
        end
        wb = 32'hF8000000;
    endtask

    // Present one beat and return one tick after the edge that accepts it.
    task automatic send_beat0(input logic [9*N-1:0] f, input logic [9*N-1:0] c, input logic [N-1:0] b);
        int w;
        w = 0;
        fea0 = f; coef0 = c; bias0 = b; valid0 = 1'b1;
        @(negedge clk);
        while (!ready0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) chk("accept0_timeout", 64'(ready0), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_window0(input logic [32:0] exp);
        q0.push_back(exp);
        for (int b = 0; b < 4; b++) send_beat0(wf[b], wc[b], wb);
        valid0 = 1'b0;
    endtask

    task automatic send1(input logic [4*N-1:0] f, input logic [4*N-1:0] c, input logic [N-1:0] b, input logic [32:0] exp);
        int w;
        w = 0;
        q1.push_back(exp);
        fea1 = f; coef1 = c; bias1 = b; valid1 = 1'b1;
        @(negedge clk);
        while (!ready1 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) chk("accept1_timeout", 64'(ready1), 64'd1);
        @(posedge clk);
        #1;
        valid1 = 1'b0;
    endtask

    // Scoreboard: compare every result handed off to the consumer.
    always @(negedge clk) begin
        if (rst && o_valid0 && o_ready0) begin
            chk("q0_avail", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) chk("score0", {o_sat0, o_data0}, q0.pop_front());
        end
        if (rst && o_valid1 && o_ready1) begin
            chk("q1_avail", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) chk("score1", {o_sat1, o_data1}, q1.pop_front());
        end
    end

    // Random consumer backpressure during the random phases.
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy0) o_ready0 = 1'($urandom_range(0, 1));
        if (rnd_rdy1) o_ready1 = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4*N-1:0] f1, c1;
        logic [N-1:0]   b1;
        int w;

        // Reset values
        idle(3);
        chk("rst_data", o_data0, 32'h0);
        chk("rst_sat", o_sat0, 1'b0);
        chk("rst_valid", o_valid0, 1'b0);
        rst = 1'b1;
        idle(1);
        chk("rst_iready", ready0, 1'b1);

        // Basic window with output latency check
        win_basic();
        send_window0({1'b0, 32'h08000000});
        idle(1);
        chk("lat_t1", o_valid0, 1'b0);
        idle(1);
        chk("lat_t2", o_valid0, 1'b1);

        // Saturation both directions
        clear_win();
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 9; k++) begin
                wf[b][k*N +: N] = 32'h10000000;
                wc[b][k*N +: N] = 32'h08000000;
            end
        send_window0({1'b1, 32'h7FFFFFFF});
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 9; k++) wc[b][k*N +: N] = 32'hF8000000;
        send_window0({1'b1, 32'h80000000});

        // Rounding: half up on dut0, truncation on dut1
        clear_win();
        wf[0][31:0] = 32'h00000001;
        wc[0][31:0] = 32'h08000000;
        send_window0({1'b0, 32'h00000001});
        wf[0][31:0] = 32'hFFFFFFFF;
        send_window0({1'b0, 32'h00000000});
        f1 = '0; c1 = '0;
        f1[31:0] = 32'h00000001;
        c1[31:0] = 32'h08000000;
        send1(f1, c1, 32'h0, {1'b0, 32'h00000000});
        f1[31:0] = 32'hFFFFFFFF;
        send1(f1, c1, 32'h0, {1'b0, 32'hFFFFFFFF});

        // Backpressure across two back-to-back windows
        idle(4);
        o_ready0 = 1'b0;
        fork
            begin
                win_basic();
                send_window0({1'b0, 32'h08000000});
                clear_win();
                for (int b = 0; b < 4; b++) begin
                    wf[b][3*N +: N] = 32'h20000000;
                    wc[b][3*N +: N] = 32'hF0000000;
                end
                wb = 32'h04000000;
                send_window0({1'b0, 32'h84000000});
            end
            begin
                w = 0;
                @(negedge clk);
                while (!o_valid0 && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                for (int i = 0; i < 5; i++) begin
                    chk("stall_data", o_data0, 32'h08000000);
                    chk("stall_iready", ready0, 1'b0);
                    if (i < 4) @(negedge clk);
                end
                @(posedge clk);
                #1;
                o_ready0 = 1'b1;
            end
        join

        // Abort with i_clear on beat 2, then a clean window
        idle(6);
        win_basic();
        wf[0][5*N +: N] = 32'h30000000;
        wc[0][5*N +: N] = 32'h10000000;
        send_beat0(wf[0], wc[0], wb);
        send_beat0(wf[1], wc[1], wb);
        clear0 = 1'b1;
        send_beat0(wf[2], wc[2], wb);
        clear0 = 1'b0;
        valid0 = 1'b0;
        chk("clr_ovalid", o_valid0, 1'b0);
        win_basic();
        send_window0({1'b0, 32'h08000000});

        // Asynchronous reset mid-window, then a clean window
        idle(4);
        wf[0][5*N +: N] = 32'h30000000;
        wc[0][5*N +: N] = 32'h10000000;
        send_beat0(wf[0], wc[0], wb);
        send_beat0(wf[1], wc[1], wb);
        valid0 = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_data", o_data0, 32'h0);
        chk("arst_sat", o_sat0, 1'b0);
        chk("arst_valid", o_valid0, 1'b0);
        idle(1);
        rst = 1'b1;
        idle(1);
        chk("arst_iready", ready0, 1'b1);
        win_basic();
        send_window0({1'b0, 32'h08000000});

        // Random windows on dut0 with random backpressure
        rnd_rdy0 = 1'b1;
        for (int n = 0; n < 60; n++) begin
            for (int b = 0; b < 4; b++)
                for (int k = 0; k < 9; k++) begin
                    wf[b][k*N +: N] = rnd_val();
                    wc[b][k*N +: N] = rnd_val();
                end
            wb = rnd_val();
            send_window0(model0());
        end

        // Random single-beat windows on dut1 with random backpressure
        rnd_rdy1 = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 4; k++) begin
                f1[k*N +: N] = rnd_val();
                c1[k*N +: N] = rnd_val();
            end
            b1 = rnd_val();
            send1(f1, c1, b1, model1(f1, c1, b1));
        end

        // Drain
        rnd_rdy0 = 1'b0;
        rnd_rdy1 = 1'b0;
        idle(1);
        o_ready0 = 1'b1;
        o_ready1 = 1'b1;
        w = 0;
        while ((q0.size() != 0 || q1.size() != 0) && w < 200) begin
            idle(1);
            w++;
        end
        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
